bit_stuffer_stream: RTL and testbench
=====================================

# bit_stuffer_stream

Parametrised, flow-controlled bit stuffer for the USB transmit path. Accepts a serial bit stream with valid/ready handshaking and packet framing, and inserts a `0` after every `RUN_LEN` consecutive `1`s. Upstream is back-pressured for exactly one slot per inserted bit, and a per-packet stuff count is reported. It sits between the packet serializer and the line driver; NRZI encoding can be compiled in.

## Interface

Parameters:
- `RUN_LEN`, 6, number of consecutive `1`s that triggers a stuff bit; legal range ≥ 2.
- `STUFF_CNT_W`, 8, width of the per-packet stuff counter.

Ports:
- `clk` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous flush; has priority over all other inputs.
- `in_bit` in 1: input data bit.
- `in_valid` in 1: `in_bit` and `in_last` are valid.
- `in_last` in 1: this bit is the final bit of the packet.
- `in_ready` out 1: block accepts the input this cycle (combinational).
- `out_bit` out 1: stuffed bit, NRZI-encoded if the macro is defined.
- `out_valid` out 1: output register holds a bit.
- `out_last` out 1: final bit of the packet (data or stuff bit).
- `out_ready` in 1: downstream consumes the output this cycle.
- `stuff_count` out `STUFF_CNT_W`: number of stuff bits inserted in the packet just ended.
- `stuff_count_valid` out 1: one-cycle pulse qualifying `stuff_count`.

## Operation

- Transfers complete on the rising edge where both valid and ready are high; this applies to both the input and output sides.
- Output slot is free when `!out_valid || out_ready`.
- The run counter is `$clog2(RUN_LEN+1)` bits wide and is internal.
- State machine (two states):
  - **PASS:**
    - `in_ready = slot_free && !clear`.
    - On accept, the output register loads `in_bit`.
    - Run counter: `in_bit==1` increments it; `in_bit==0` zeroes it.
    - If `run==RUN_LEN-1 && in_bit==1`: go to STUFF, zero the run counter, and save `in_last` as `pend_last`. `out_last` is 0 on this bit.
    - Otherwise `out_last = in_last`.
  - **STUFF:**
    - `in_ready = 0`.
    - When the slot is free, load bit `0` with `out_last = pend_last`, then return to PASS.
- Packet boundary: when a bit with `out_last=1` is loaded, zero the run counter. Runs never carry across packets.
- Stuff counter:
  - Increments (saturating at all-ones) each time a stuff bit is loaded.
  - When a bit with `out_last=1` is loaded, `stuff_count` latches the final total (including that bit), `stuff_count_valid` pulses next cycle, and the internal counter zeroes.
- `clear` (synchronous, on the clock edge where it is high):
  - Forces PASS and `out_valid=0`.
  - Zeroes the run and stuff counters.
  - Drops any pending stuff bit.
  - Does not pulse `stuff_count_valid`.

## Timing

- Reset values: state PASS, `out_valid=0`, `out_bit=0` (1 with NRZI), `out_last=0`, `stuff_count=0`, `stuff_count_valid=0`, counters 0.
- `in_ready` is 1 in the first cycle after reset.
- Latency is one cycle from input accept to `out_valid`.
- Throughput is one bit per cycle with `out_ready` held high. Each stuff bit costs exactly one cycle of `in_ready=0`.
- While `out_valid && !out_ready`: `out_bit` and `out_last` are stable, and no load occurs.
- Simultaneous drain and load (`out_valid && out_ready` with a new bit) keeps `out_valid` high with no bubble. This applies in both PASS and STUFF.
- `in_ready` has no combinational path from `in_valid`.
- `nRST` asserted mid-packet discards all state immediately.

## Configuration

- Macro `BIT_STUFFER_NRZI_EN`:
  - **Defined:** `out_bit` is the NRZI line level.
    - A `0` toggles the level; a `1` holds it.
    - The level updates on each load into the output register.
    - Idle/reset level is 1 (J).
    - After a transfer with `out_last=1`, or on `clear`, the level returns to 1.
  - **Undefined:** `out_bit` is the raw stuffed bit; no level register exists.

## Structure

- Package `bit_stuff_pkg`:
  - State enum `stuff_state_t {PASS, STUFF}`.
  - `USB_RUN_LEN = 6`.
  - `NRZI_IDLE_LEVEL = 1'b1`.
- Sub-module `nrzi_encoder` (load, last, clear → level), instantiated only under `BIT_STUFFER_NRZI_EN`.

## Test plan

- **Basic insertion:** `RUN_LEN=6`, `out_ready=1`, input `1111111 0` → output `111111 0 1 0`. `in_ready` is low for exactly the one cycle after the 6th `1` is accepted.
- **Last bit triggers stuff:** packet `0 111111` with the last `1` flagged → stuff `0` carries `out_last=1`, and the previous bit has `out_last=0`. `stuff_count_valid` pulses with `stuff_count=1`.
- **Back-pressure in STUFF:** hold `out_ready=0` for 3 cycles while STUFF is pending → `out_bit`/`out_valid` stable, `in_ready=0`, and the full sequence arrives intact with no bit lost or duplicated.
- **Packet boundary:** packet A `111` (last), packet B `111111 0` → no stuff in A or across the boundary; exactly one stuff after B's 6th `1`. Counts reported: A=0, B=1.
- **Clear mid-stuff:** assert `clear` in STUFF → `out_valid=0` next cycle and no stuff bit emitted. Next input `1` starts a run of 1 (five more `1`s are needed before a stuff).
- **NRZI:** with `BIT_STUFFER_NRZI_EN`, raw `0 1 1 0` from reset → `out_bit` `0 0 0 1`. After a last-flagged transfer, the level reads 1.

Source files
------------

// File: rtl/bit_stuff_pkg.sv
// bit_stuff_pkg: shared state type and constants for the USB bit stuffer
package bit_stuff_pkg;
    typedef enum logic {PASS, STUFF} stuff_state_t;
    localparam int USB_RUN_LEN = 6;
    localparam logic NRZI_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/nrzi_encoder.sv
// nrzi_encoder: NRZI line level that returns to idle J after a packet's last bit drains
module nrzi_encoder
    import bit_stuff_pkg::*;
(
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    input  logic load,
    input  logic data,
    input  logic last,
    output logic level
);
    logic base;
    assign base = last ? NRZI_IDLE_LEVEL : level;
    // a 0 toggles the level and a 1 holds it; a new packet starts from idle
    always_ff @(posedge clk or negedge nRST)
        if (!nRST) level <= NRZI_IDLE_LEVEL;
        else if (clear) level <= NRZI_IDLE_LEVEL;
        else if (load) level <= data ? base : ~base;
        else if (last) level <= NRZI_IDLE_LEVEL;
endmodule

// File: rtl/bit_stuffer_stream.sv
// bit_stuffer_stream: valid/ready bit stuffer inserting a 0 after RUN_LEN ones; NRZI output when BIT_STUFFER_NRZI_EN is defined
module bit_stuffer_stream
    import bit_stuff_pkg::*;
#(
    parameter int RUN_LEN = USB_RUN_LEN,
    parameter int STUFF_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   clear,
    input  logic                   in_bit,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_bit,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [STUFF_CNT_W-1:0] stuff_count,
    output logic                   stuff_count_valid
);
    localparam int RW = $clog2(RUN_LEN + 1);
    stuff_state_t state, state_n;
    logic [RW-1:0] run, run_n;
    logic [STUFF_CNT_W-1:0] cnt, cnt_inc;
    logic pend_last, slot_free, accept, stuff_load, load, load_bit, load_last, trigger;
    // handshake, next state and the bit loaded into the output register this cycle
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready = state == PASS && slot_free && !clear;
        accept = in_valid && in_ready;
        stuff_load = state == STUFF && slot_free && !clear;
        trigger = accept && in_bit && run == RW'(RUN_LEN - 1);
        load = accept || stuff_load;
        load_bit = accept && in_bit;
        load_last = stuff_load ? pend_last : accept && in_last && !trigger;
        run_n = run;
        if (accept) run_n = (in_bit && !trigger) ? run + 1'b1 : '0;
        if (load_last) run_n = '0;
        cnt_inc = (stuff_load && cnt != '1) ? cnt + 1'b1 : cnt;
        state_n = clear ? PASS : trigger ? STUFF : stuff_load ? PASS : state;
    end
    // state register
    always_ff @(posedge clk or negedge nRST)
        if (!nRST) state <= PASS;
        else state <= state_n;
    // output register, run and stuff counters, per-packet stuff report
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            run <= '0;
            cnt <= '0;
            pend_last <= 1'b0;
            stuff_count <= '0;
            stuff_count_valid <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            run <= '0;
            cnt <= '0;
            pend_last <= 1'b0;
            stuff_count_valid <= 1'b0;
        end else begin
            run <= run_n;
            cnt <= load_last ? '0 : cnt_inc;
            stuff_count_valid <= load_last;
            if (load_last) stuff_count <= cnt_inc;
            if (trigger) pend_last <= in_last;
            if (load) begin
                out_valid <= 1'b1;
                out_last <= load_last;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
`ifdef BIT_STUFFER_NRZI_EN
    nrzi_encoder u_nrzi (
        .clk   (clk),
        .nRST  (nRST),
        .clear (clear),
        .load  (load),
        .data  (load_bit),
        .last  (out_valid && out_ready && out_last),
        .level (out_bit)
    );
`else
    // raw stuffed bit held until the next load
    always_ff @(posedge clk or negedge nRST)
        if (!nRST) out_bit <= 1'b0;
        else if (load) out_bit <= load_bit;
`endif
endmodule

// File: tb/tb_bit_stuffer_stream.sv
// tb_bit_stuffer_stream: directed bench for bit_stuffer_stream with a packet-level stuffing model
module tb_bit_stuffer_stream;
    localparam int RL = 6;
    localparam int CW = 8;
`ifdef BIT_STUFFER_NRZI_EN
    localparam logic IDLE_BIT = 1'b1;
`else
    localparam logic IDLE_BIT = 1'b0;
`endif
    logic clk = 0, nRST = 0, clear = 0, in_bit = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic in_ready, out_bit, out_valid, out_last, stuff_count_valid;
    logic [CW-1:0] stuff_count;
    int n_cmp = 0, n_bad = 0;
    bit model_on = 0;
    bit exp_b[$], exp_l[$], log_b[$], log_l[$];
    int exp_c[$], log_c[$], stall_log[$];
    logic lvl = 1'b1;

    bit_stuffer_stream #(.RUN_LEN(RL), .STUFF_CNT_W(CW)) dut (
        .clk(clk), .nRST(nRST), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .stuff_count(stuff_count),
        .stuff_count_valid(stuff_count_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // expected line stream of one packet: a 0 after every RL ones, last flag moves onto a trailing stuff bit
    task automatic model_pkt(input bit q[$], input bit lf);
        int run = 0, cnt = 0;
        foreach (q[i]) begin
            bit il;
            il = lf && i == q.size() - 1;
            run = q[i] ? run + 1 : 0;
            if (run == RL) begin
                exp_b.push_back(1); exp_l.push_back(0);
                exp_b.push_back(0); exp_l.push_back(il);
                cnt++;
                run = 0;
            end else begin
                exp_b.push_back(q[i]); exp_l.push_back(il);
            end
        end
        if (lf) exp_c.push_back(cnt > 255 ? 255 : cnt);
    endtask

    // compare every output transfer and every count report against the model
    always @(negedge clk) begin : cmp
        bit b, l;
        logic e;
        if (nRST && model_on) begin
            if (out_valid && out_ready) begin
                if (exp_b.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    b = exp_b.pop_front();
                    l = exp_l.pop_front();
                    e = b ? lvl : ~lvl;
                    lvl = l ? 1'b1 : e;
`ifndef BIT_STUFFER_NRZI_EN
                    e = b;
`endif
                    chk("out_bit", out_bit, e);
                    chk("out_last", out_last, l);
                    log_b.push_back(out_bit);
                    log_l.push_back(out_last);
                end
            end
            if (stuff_count_valid) begin
                if (exp_c.size() == 0) chk("unexpected_cnt", 1, 0);
                else chk("stuff_count", stuff_count, exp_c.pop_front());
                log_c.push_back(stuff_count);
            end
        end
    end

    task automatic send_bit(input bit b, input bit l);
        bit acc = 0;
        int st = 0;
        in_valid = 1; in_bit = b; in_last = l;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) st++;
        end
        if (!acc) chk("accept_timeout", acc, 1);
        stall_log.push_back(st);
        in_valid = 0; in_last = 0;
    endtask

    task automatic send_q(input bit q[$], input bit lf);
        if (model_on) model_pkt(q, lf);
        foreach (q[i]) send_bit(q[i], lf && i == q.size() - 1);
    endtask

    task automatic send_vec(input logic [63:0] v, input int n, input bit lf);
        bit q[$];
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
        send_q(q, lf);
    endtask

    task automatic drain();
        bit idle = 0;
        for (int k = 0; k < 60 && !idle; k++) begin
            @(negedge clk);
            idle = !out_valid;
        end
        chk("drain", idle, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_b.delete(); log_l.delete(); log_c.delete(); stall_log.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit q[$];
        int s;
        logic ob;
        repeat (3) @(posedge clk);
        @(negedge clk) nRST = 1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_bit", out_bit, IDLE_BIT);
        chk("rst_stuff_count", stuff_count, 0);
        chk("rst_count_valid", stuff_count_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        model_on = 1;
`ifdef BIT_STUFFER_NRZI_EN
        clear_logs();
        send_vec(4'b0110, 4, 1);
        drain();
        chk("nrzi_levels", pack(log_b), 4'b0001);
        chk("nrzi_idle_after_last", out_bit, 1);
`endif
        clear_logs();
        send_vec(8'b11111110, 8, 1);
        drain();
`ifndef BIT_STUFFER_NRZI_EN
        chk("basic_bits", pack(log_b), 9'b111111010);
        chk("basic_last", pack(log_l), 9'b000000001);
`endif
        s = 0;
        foreach (stall_log[i]) s += stall_log[i];
        chk("basic_stall_7th", stall_log.size() == 8 ? stall_log[6] : -1, 1);
        chk("basic_stall_total", s, 1);
        chk("basic_cnt", log_c.size() == 1 ? log_c[0] : -1, 1);

        clear_logs();
        send_vec(7'b0111111, 7, 1);
        drain();
`ifndef BIT_STUFFER_NRZI_EN
        chk("lasttrig_bits", pack(log_b), 8'b01111110);
`endif
        chk("lasttrig_last", pack(log_l), 8'b00000001);
        chk("lasttrig_cnt", log_c.size() == 1 ? log_c[0] : -1, 1);

        fork
            send_vec(8'b11111110, 8, 1);
            begin
                bit seen = 0;
                for (int k = 0; k < 30 && !seen; k++) begin
                    @(posedge clk);
                    #2;
                    seen = !in_ready;
                end
                chk("bp_stuff_seen", seen, 1);
                out_ready = 0;
                ob = out_bit;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_hold_bit", out_bit, ob);
                    chk("bp_hold_valid", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #2;
                out_ready = 1;
            end
        join
        drain();

        clear_logs();
        send_vec(3'b111, 3, 1);
        send_vec(7'b1111110, 7, 1);
        drain();
        chk("boundary_cnt_a", log_c.size() == 2 ? log_c[0] : -1, 0);
        chk("boundary_cnt_b", log_c.size() == 2 ? log_c[1] : -1, 1);

        model_on = 0;
        repeat (12) send_bit(1, 0);
        chk("clr_in_stuff", in_ready, 0);
        clear = 1;
        @(posedge clk);
        #1;
        clear = 0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_count_valid", stuff_count_valid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("clr_no_stuff", out_valid, 0);
        end
        @(posedge clk);
        #1;
        lvl = 1'b1;
        model_on = 1;
        clear_logs();
        send_vec(6'b111111, 6, 1);
        send_vec(6'b111110, 6, 1);
        drain();
        chk("clr_cnt_first", log_c.size() == 2 ? log_c[0] : -1, 1);
        chk("clr_cnt_second", log_c.size() == 2 ? log_c[1] : -1, 0);

        model_on = 0;
        repeat (3) send_bit(1, 0);
        clear = 1;
        @(posedge clk);
        #1;
        clear = 0;
        drain();
        lvl = 1'b1;
        model_on = 1;
        send_vec(5'b11110, 5, 1);
        drain();

        fork
            send_vec(40'hFF_FBFF_7E3F, 40, 1);
            begin
                logic [31:0] pat = 32'b1101_0111_0011_1010_1111_0110_1001_1110;
                for (int k = 31; k >= 0; k--) begin
                    @(posedge clk);
                    #2;
                    out_ready = pat[k];
                end
                @(posedge clk);
                #2;
                out_ready = 1;
            end
        join
        drain();

        clear_logs();
        q.delete();
        repeat (257 * RL) q.push_back(1);
        send_q(q, 1);
        drain();
        chk("sat_cnt", log_c.size() == 1 ? log_c[0] : -1, 255);

        model_on = 0;
        repeat (3) send_bit(1, 0);
        in_valid = 1; in_bit = 1;
        repeat (2) @(posedge clk);
        #1;
        nRST = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_out_bit", out_bit, IDLE_BIT);
        chk("arst_stuff_count", stuff_count, 0);
        in_valid = 0;
        @(negedge clk) nRST = 1;
        @(posedge clk);
        #1;
        chk("arst_in_ready", in_ready, 1);
        exp_b.delete(); exp_l.delete(); exp_c.delete();
        lvl = 1'b1;
        model_on = 1;
        send_vec(6'b111110, 6, 1);
        drain();

        chk("exp_bits_left", exp_b.size(), 0);
        chk("exp_cnts_left", exp_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
